fir_seq_ctrl: RTL

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/fir_seq_ctrl.sv
// Sample sequencer between an ADC source, a fixed-latency FIR and a downstream sink.
// Keeps one sample in flight, drops warm-up results and ends bursts on count or stop.
module fir_seq_ctrl #(
  parameter int unsigned WARMUP  = 3,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  burst_len,
  input  logic        adc_valid,
  input  logic [15:0] adc_data,
  output logic        adc_ready,
  output logic        fir_enable,
  output logic [15:0] fir_data_in,
  input  logic [17:0] fir_data_out,
  input  logic        fir_done,
  output logic        out_valid,
  output logic [17:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        err_timeout,
  output logic [7:0]  out_cnt
);

  localparam int unsigned WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] WARMUP_W = WW'(WARMUP);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    burst_q, burst_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [15:0]   sample_q, sample_d;
  logic [17:0]   result_q, result_d;
  logic [7:0]    cnt_inc;
  logic          burst_end;

  assign cnt_inc   = cnt_q + 8'd1;
  assign burst_end = (burst_q != 8'd0) && (cnt_inc == burst_q);

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    cnt_d    = cnt_q;
    warm_d   = warm_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    sample_d = sample_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          burst_d = burst_len;
          cnt_d   = '0;
          warm_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_FETCH: begin
        if (adc_valid) begin
          sample_d = adc_data;
          state_d  = ST_ISSUE;
        end else if (stop) begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_d = tmo_q + 1'b1;
        // A result that lands on the last allowed cycle still wins over the timeout.
        if (fir_done) begin
          result_d = fir_data_out;
          if (warm_q < WARMUP_W) begin
            warm_d  = warm_q + 1'b1;
            state_d = stop ? ST_IDLE : ST_FETCH;
          end else begin
            state_d = ST_OUT;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          cnt_d   = cnt_inc;
          state_d = (burst_end || stop) ? ST_IDLE : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      burst_q  <= '0;
      cnt_q    <= '0;
      warm_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
      sample_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      cnt_q    <= cnt_d;
      warm_q   <= warm_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      sample_q <= sample_d;
      result_q <= result_d;
    end
  end

  assign adc_ready   = (state_q == ST_FETCH);
  assign fir_enable  = (state_q == ST_ISSUE);
  assign out_valid   = (state_q == ST_OUT);
  assign busy        = (state_q != ST_IDLE);
  assign fir_data_in = sample_q;
  assign out_data    = result_q;
  assign err_timeout = err_q;
  assign out_cnt     = cnt_q;

endmodule
